// File: rtl/echo_pkg.sv
// -----------------------------------------------------------------------------
// echo_pkg
// Shared definitions for the echo input sequencer, which sits upstream of the
// 4-bit code converter / seven-segment decoder.
//   state_t   : sequencer FSM encoding (also exported on the debug port)
//   CODE_W    : width of the code handed to the decoder (E1..E4)
//   CODE_MAX  : last code of the auto-step walk before it wraps to 0
//   code_next : modulo-16 increment used by the auto-step walk
// -----------------------------------------------------------------------------
package echo_pkg;

  localparam int CODE_W = 4;
  localparam logic [CODE_W-1:0] CODE_MAX = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHOW  = 2'd1,
    ST_AUTO  = 2'd2,
    ST_BLANK = 2'd3
  } state_t;

  // Wrap explicitly at CODE_MAX so the walk stays correct even if CODE_W is
  // ever widened while the display only understands 0..15.
  function automatic logic [CODE_W-1:0] code_next(input logic [CODE_W-1:0] c);
    logic [CODE_W-1:0] n;
    if (c == CODE_MAX) begin
      n = '0;
    end else begin
      n = c + CODE_W'(1);
    end
    return n;
  endfunction

endpackage

// File: rtl/echo_debounce.sv
// -----------------------------------------------------------------------------
// echo_debounce
// Conditions one raw asynchronous input: a 2-flop synchronizer followed by a
// debounce counter. The debounced value only follows the synchronized value
// after it has differed for DEB_CYCLES consecutive cycles, so any glitch
// shorter than DEB_CYCLES cycles is invisible downstream.
//
// Ports:
//   clk  in  system clock, all state on the rising edge
//   rst  in  synchronous active-high reset, clears every flop to 0
//   raw  in  raw asynchronous input
//   deb  out debounced, registered value
//
// Parameters:
//   DEB_CYCLES  stable cycles needed before deb changes
//   DEB_W       counter width, 2**DEB_W must exceed DEB_CYCLES
// -----------------------------------------------------------------------------
module echo_debounce #(
  parameter int DEB_CYCLES = 50000,
  parameter int DEB_W      = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic deb
);

  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             deb_q;
  logic [DEB_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      deb_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      // Any cycle where the synchronized value agrees with the debounced one
      // restarts the count, so only an unbroken run can flip deb.
      if (sync2_q == deb_q) begin
        cnt_q <= '0;
      end else if (cnt_q == DEB_LAST) begin
        deb_q <= sync2_q;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + DEB_W'(1);
      end
    end
  end

  assign deb = deb_q;

endmodule

// File: rtl/echo_input_sequencer.sv
// -----------------------------------------------------------------------------
// echo_input_sequencer
// Front end of the code converter / seven-segment decoder. Debounces four data
// switches and three control buttons, holds a stable 4-bit code and drives the
// decoder's E1..E4, RE and RS (here RSO) inputs. An auto-step mode walks the
// codes 0..15 for a display self-test.
//
// Ports:
//   CLK        in   system clock, rising edge
//   RS         in   synchronous active-high reset (aborts any state)
//   SW[3:0]    in   raw data switches, SW[3] -> E1 ... SW[0] -> E4
//   LOAD       in   raw load button (rising edge latches SW)
//   CLR        in   raw clear button (rising edge blanks the display)
//   AUTO       in   raw auto-step mode switch (level)
//   E1..E4     out  registered code, E1 = MSB
//   RE         out  code-valid enable (SHOW and AUTO)
//   RSO        out  blank request, high only in BLANK
//   dbg_state  out  current FSM state for observation
//
// Handshake/ordering: there is no valid/ready handshake here. Control events
// are debounced rising edges (LOAD, CLR) or a debounced level (AUTO), arbitrated
// each cycle as CLR rise > AUTO level > LOAD rise. Every output comes straight
// from a flop, so nothing on an input reaches an output in the same cycle.
// -----------------------------------------------------------------------------
module echo_input_sequencer
  import echo_pkg::*;
#(
  parameter int DEB_CYCLES   = 50000,
  parameter int DEB_W        = 16,
  parameter int STEP_CYCLES  = 50000000,
  parameter int STEP_W       = 26,
  parameter int BLANK_CYCLES = 8
) (
  input  logic        CLK,
  input  logic        RS,
  input  logic [3:0]  SW,
  input  logic        LOAD,
  input  logic        CLR,
  input  logic        AUTO,
  output logic        E1,
  output logic        E2,
  output logic        E3,
  output logic        E4,
  output logic        RE,
  output logic        RSO,
  output logic [1:0]  dbg_state
);

  localparam int BLANK_W = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
  localparam logic [STEP_W-1:0]  STEP_LAST  = STEP_W'(STEP_CYCLES - 1);
  localparam logic [BLANK_W-1:0] BLANK_LAST = BLANK_W'(BLANK_CYCLES - 1);

  // ---------------------------------------------------------------------------
  // Input conditioning: seven identical synchronizer + debounce channels.
  // ---------------------------------------------------------------------------
  logic [CODE_W-1:0] sw_deb;
  logic              load_deb;
  logic              clr_deb;
  logic              auto_deb;

  for (genvar i = 0; i < CODE_W; i++) begin : g_sw_deb
    echo_debounce #(
      .DEB_CYCLES (DEB_CYCLES),
      .DEB_W      (DEB_W)
    ) u_sw_deb (
      .clk (CLK),
      .rst (RS),
      .raw (SW[i]),
      .deb (sw_deb[i])
    );
  end

  echo_debounce #(
    .DEB_CYCLES (DEB_CYCLES),
    .DEB_W      (DEB_W)
  ) u_load_deb (
    .clk (CLK),
    .rst (RS),
    .raw (LOAD),
    .deb (load_deb)
  );

  echo_debounce #(
    .DEB_CYCLES (DEB_CYCLES),
    .DEB_W      (DEB_W)
  ) u_clr_deb (
    .clk (CLK),
    .rst (RS),
    .raw (CLR),
    .deb (clr_deb)
  );

  echo_debounce #(
    .DEB_CYCLES (DEB_CYCLES),
    .DEB_W      (DEB_W)
  ) u_auto_deb (
    .clk (CLK),
    .rst (RS),
    .raw (AUTO),
    .deb (auto_deb)
  );

  // ---------------------------------------------------------------------------
  // Rise detection on the debounced buttons. A held button produces exactly one
  // event, so holding LOAD or CLR never retriggers.
  // ---------------------------------------------------------------------------
  logic load_prev_q;
  logic clr_prev_q;
  logic load_rise;
  logic clr_rise;

  always_ff @(posedge CLK) begin
    if (RS) begin
      load_prev_q <= 1'b0;
      clr_prev_q  <= 1'b0;
    end else begin
      load_prev_q <= load_deb;
      clr_prev_q  <= clr_deb;
    end
  end

  assign load_rise = load_deb & ~load_prev_q;
  assign clr_rise  = clr_deb  & ~clr_prev_q;

  // ---------------------------------------------------------------------------
  // Sequencer FSM, code register and step/blank counters.
  // ---------------------------------------------------------------------------
  state_t             state_q;
  state_t             state_n;
  logic [CODE_W-1:0]  code_q;
  logic [CODE_W-1:0]  code_n;
  logic [STEP_W-1:0]  step_q;
  logic [STEP_W-1:0]  step_n;
  logic [BLANK_W-1:0] blank_q;
  logic [BLANK_W-1:0] blank_n;
  logic               re_q;
  logic               rso_q;

  always_comb begin
    state_n = state_q;
    code_n  = code_q;
    step_n  = step_q;
    blank_n = blank_q;

    case (state_q)
      ST_IDLE, ST_SHOW: begin
        if (clr_rise) begin
          // A LOAD rising in the same cycle is simply dropped.
          state_n = ST_BLANK;
          code_n  = '0;
          blank_n = '0;
        end else if (auto_deb) begin
          state_n = ST_AUTO;
          code_n  = '0;
          step_n  = '0;
        end else if (load_rise) begin
          state_n = ST_SHOW;
          code_n  = sw_deb;
        end
      end

      ST_AUTO: begin
        if (clr_rise) begin
          state_n = ST_BLANK;
          code_n  = '0;
          blank_n = '0;
        end else if (!auto_deb) begin
          // Leaving self-test freezes whatever code is currently shown.
          state_n = ST_SHOW;
        end else if (step_q == STEP_LAST) begin
          step_n = '0;
          code_n = code_next(code_q);
        end else begin
          step_n = step_q + STEP_W'(1);
        end
      end

      ST_BLANK: begin
        // Buttons are ignored here; the code is forced to 0 so the data lines
        // stay low for the whole time RSO is asserted.
        code_n = '0;
        if (blank_q == BLANK_LAST) begin
          state_n = ST_IDLE;
        end else begin
          blank_n = blank_q + BLANK_W'(1);
        end
      end

      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RS) begin
      state_q <= ST_IDLE;
      code_q  <= '0;
      step_q  <= '0;
      blank_q <= '0;
      re_q    <= 1'b0;
      rso_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      code_q  <= code_n;
      step_q  <= step_n;
      blank_q <= blank_n;
      // RE/RSO are decoded from the next state so they are true flops that
      // line up with the state they describe.
      re_q    <= (state_n == ST_SHOW) || (state_n == ST_AUTO);
      rso_q   <= (state_n == ST_BLANK);
    end
  end

  assign E1        = code_q[3];
  assign E2        = code_q[2];
  assign E3        = code_q[1];
  assign E4        = code_q[0];
  assign RE        = re_q;
  assign RSO       = rso_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_echo_input_sequencer.sv
// -----------------------------------------------------------------------------
// tb_echo_input_sequencer
// Directed bench for echo_input_sequencer with short timing parameters
// (DEB_CYCLES=4, STEP_CYCLES=3, BLANK_CYCLES=2). A raw change made before
// clock edge e0 shows up on the outputs after edge e6.
// Observed word: {state[1:0], E1, E2, E3, E4, RE, RSO}.
// -----------------------------------------------------------------------------
module tb_echo_input_sequencer;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHOW  = 2'd1;
  localparam logic [1:0] S_AUTO  = 2'd2;
  localparam logic [1:0] S_BLANK = 2'd3;

  // Auto phase: AUTO is dropped right after this tick, SHOW appears 7 ticks
  // later holding the code shown 6 ticks later (code 9 on the second lap).
  localparam int AUTO_DROP = 77;

  logic       CLK;
  logic       RS;
  logic [3:0] SW;
  logic       LOAD;
  logic       CLR;
  logic       AUTO;
  logic       E1, E2, E3, E4, RE, RSO;
  logic [1:0] dbg_state;

  int checks_total  = 0;
  int checks_passed = 0;

  logic [7:0] exp_q[$];

  echo_input_sequencer #(
    .DEB_CYCLES   (4),
    .DEB_W        (3),
    .STEP_CYCLES  (3),
    .STEP_W       (2),
    .BLANK_CYCLES (2)
  ) dut (
    .CLK       (CLK),
    .RS        (RS),
    .SW        (SW),
    .LOAD      (LOAD),
    .CLR       (CLR),
    .AUTO      (AUTO),
    .E1        (E1),
    .E2        (E2),
    .E3        (E3),
    .E4        (E4),
    .RE        (RE),
    .RSO       (RSO),
    .dbg_state (dbg_state)
  );

  // ---------------------------------------------------------------- clock
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------------------------------------------------------- helpers
  function automatic logic [7:0] pack(input logic [1:0] st, input logic [3:0] code,
                                      input logic re, input logic rso);
    return {st, code, re, rso};
  endfunction

  function automatic logic [7:0] observed();
    return {dbg_state, E1, E2, E3, E4, RE, RSO};
  endfunction

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] want);
    checks_total++;
    if (got === want) begin
      checks_passed++;
    end else begin
      $display("FAIL %s: got st=%0d code=%b re=%b rso=%b, expected st=%0d code=%b re=%b rso=%b",
               tag, got[7:6], got[5:2], got[1], got[0], want[7:6], want[5:2], want[1], want[0]);
    end
  endtask

  // Advance one clock and land 1 time unit after the edge for sampling/driving.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    RS   = 1'b1;
    SW   = 4'b1111;
    LOAD = 1'b0;
    CLR  = 1'b0;
    AUTO = 1'b1;

    // Reset held two cycles with switches and AUTO high.
    for (int i = 1; i <= 2; i++) begin
      tick();
      check($sformatf("reset_c%0d", i), observed(), pack(S_IDLE, 4'b0000, 1'b0, 1'b0));
    end
    RS = 1'b0;
    tick();
    check("reset_first_after", observed(), pack(S_IDLE, 4'b0000, 1'b0, 1'b0));

    // One-cycle AUTO blip after reset is a glitch and must not start auto mode.
    AUTO = 1'b0;
    SW   = 4'b1010;
    ticks(10);
    check("idle_settled", observed(), pack(S_IDLE, 4'b0000, 1'b0, 1'b0));

    // Load: LOAD held 10 cycles, outputs change after the 7th edge.
    LOAD = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      tick();
      if (n < 7)
        check($sformatf("load_n%0d", n), observed(), pack(S_IDLE, 4'b0000, 1'b0, 1'b0));
      else
        check($sformatf("load_n%0d", n), observed(), pack(S_SHOW, 4'b1010, 1'b1, 1'b0));
    end
    LOAD = 1'b0;
    ticks(8);
    check("load_release_hold", observed(), pack(S_SHOW, 4'b1010, 1'b1, 1'b0));

    // SW change without LOAD, then a 3-cycle LOAD glitch: code stays 1010.
    SW = 4'b0101;
    ticks(8);
    check("sw_change_no_load", observed(), pack(S_SHOW, 4'b1010, 1'b1, 1'b0));
    LOAD = 1'b1;
    ticks(3);
    LOAD = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      tick();
      check($sformatf("glitch_n%0d", n), observed(), pack(S_SHOW, 4'b1010, 1'b1, 1'b0));
    end

    // CLR and LOAD rise together from SHOW: two BLANK cycles, then IDLE.
    CLR  = 1'b1;
    LOAD = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      tick();
      if (n < 7)
        check($sformatf("clr_n%0d", n), observed(), pack(S_SHOW, 4'b1010, 1'b1, 1'b0));
      else if (n < 9)
        check($sformatf("clr_n%0d", n), observed(), pack(S_BLANK, 4'b0000, 1'b0, 1'b1));
      else
        check($sformatf("clr_n%0d", n), observed(), pack(S_IDLE, 4'b0000, 1'b0, 1'b0));
    end
    CLR  = 1'b0;
    LOAD = 1'b0;
    ticks(8);
    check("clr_release_idle", observed(), pack(S_IDLE, 4'b0000, 1'b0, 1'b0));

    // Auto walk: 0..15, wrap, up to 9 on the second lap, then AUTO dropped.
    for (int n = 1; n <= AUTO_DROP + 12; n++) begin
      if (n < 7)
        exp_q.push_back(pack(S_IDLE, 4'b0000, 1'b0, 1'b0));
      else if (n <= AUTO_DROP + 6)
        exp_q.push_back(pack(S_AUTO, 4'(((n - 7) / 3) % 16), 1'b1, 1'b0));
      else
        exp_q.push_back(pack(S_SHOW, 4'd9, 1'b1, 1'b0));
    end
    AUTO = 1'b1;
    for (int n = 1; n <= AUTO_DROP + 12; n++) begin
      logic [7:0] want;
      tick();
      want = exp_q.pop_front();
      check($sformatf("auto_n%0d", n), observed(), want);
      if (n == AUTO_DROP) AUTO = 1'b0;
    end

    // Reset on the second BLANK cycle: IDLE next cycle, no return to BLANK.
    CLR = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      tick();
      if (n < 7)
        check($sformatf("rstblank_n%0d", n), observed(), pack(S_SHOW, 4'd9, 1'b1, 1'b0));
      else
        check($sformatf("rstblank_n%0d", n), observed(), pack(S_BLANK, 4'b0000, 1'b0, 1'b1));
    end
    RS  = 1'b1;
    CLR = 1'b0;
    tick();
    check("rstblank_reset", observed(), pack(S_IDLE, 4'b0000, 1'b0, 1'b0));
    RS = 1'b0;
    for (int n = 10; n <= 20; n++) begin
      tick();
      check($sformatf("rstblank_n%0d", n), observed(), pack(S_IDLE, 4'b0000, 1'b0, 1'b0));
    end

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

  // Time guard so the run always ends on its own.
  initial begin
    #100000;
    $display("FAIL timeout: got no completion, expected finish before 100000");
    $fatal(1);
  end

endmodule
